// File: rtl/fetch_unit_if.sv
// Bundles the fetch unit's redirect input, its memory fetch port and its decode handshake port.
interface fetch_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             br_en;
  logic [WIDTH-1:0] br_target;
  logic             fe_rd_en;
  logic [WIDTH-1:0] fe_rd_addr;
  logic             fe_halt;
  logic [WIDTH-1:0] fe_rd_data;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_pc;
  logic [WIDTH-1:0] o_instr;
  logic             o_misalign;

  modport master (
    input  br_en, br_target, fe_rd_data, i_ready,
    output fe_rd_en, fe_rd_addr, fe_halt, o_valid, o_pc, o_instr, o_misalign
  );

  modport slave (
    output br_en, br_target, fe_rd_data, i_ready,
    input  fe_rd_en, fe_rd_addr, fe_halt, o_valid, o_pc, o_instr, o_misalign
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one fetch per cycle and queues {pc, instr} for decode.
// Define FETCH_MISALIGN_TRAP_EN to build the sticky misaligned-redirect flag.
module fetch_unit #(
  parameter int unsigned         WIDTH     = 32,
  parameter logic [WIDTH-1:0]    RESET_PC  = '0,
  parameter int unsigned         BUF_DEPTH = 2
) (
  input logic          clk,
  input logic          reset,
  input logic          halt,
  fetch_unit_if.master bus
);

  localparam int unsigned PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;
  localparam logic [CW:0] DepthW = (CW+1)'(BUF_DEPTH);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] req_pc_q, req_pc_d;
  logic             req_valid_q, req_valid_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] q_pc    [BUF_DEPTH];
  logic [WIDTH-1:0] q_instr [BUF_DEPTH];

  logic        pop, push, issue;
  logic [CW:0] occupancy;

  always_comb begin
    pop       = (count_q != '0) & bus.i_ready & ~halt;
    push      = req_valid_q & ~halt & ~bus.br_en;
    // Slots committed once the in-flight word lands, net of this cycle's pop.
    occupancy = {1'b0, count_q} + {{CW{1'b0}}, req_valid_q} - {{CW{1'b0}}, pop};
    issue     = ~reset & ~halt & ~bus.br_en & (occupancy < DepthW);
  end

  assign bus.fe_rd_en   = issue;
  assign bus.fe_rd_addr = pc_q;
  assign bus.fe_halt    = ~issue;
  assign bus.o_valid    = (count_q != '0);
  assign bus.o_pc       = q_pc[rd_ptr_q];
  assign bus.o_instr    = q_instr[rd_ptr_q];

  always_comb begin
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    req_valid_d = req_valid_q;
    rd_ptr_d    = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    wr_ptr_d    = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (bus.br_en) begin
      pc_d        = bus.br_target & ~WIDTH'(3);
      req_valid_d = 1'b0;
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
      count_d     = '0;
    end else if (issue) begin
      req_pc_d    = pc_q;
      pc_d        = pc_q + WIDTH'(4);
      req_valid_d = 1'b1;
    end else if (!halt) begin
      req_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      req_pc_q    <= '0;
      req_valid_q <= 1'b0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        q_pc[i]    <= '0;
        q_instr[i] <= '0;
      end
    end else begin
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      req_valid_q <= req_valid_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      if (push) begin
        q_pc[wr_ptr_q]    <= req_pc_q;
        q_instr[wr_ptr_q] <= bus.fe_rd_data;
      end
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      misalign_q <= 1'b0;
    end else if (bus.br_en && (bus.br_target[1:0] != 2'b00)) begin
      misalign_q <= 1'b1;
    end
  end

  assign bus.o_misalign = misalign_q;
`else
  assign bus.o_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed table-driven bench for fetch_unit with a one-cycle registered ROM on the fetch port.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic reset;
  logic halt;

  fetch_unit_if #(.WIDTH(32)) bus ();

  fetch_unit #(
    .WIDTH    (32),
    .RESET_PC (32'h0),
    .BUF_DEPTH(2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .halt (halt),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // ROM word i holds (i+1)*0x11.
  function automatic logic [31:0] rom(input logic [31:0] addr);
    return ((addr >> 2) + 32'd1) * 32'h11;
  endfunction

  always @(posedge clk) begin
    if (bus.fe_rd_en && !bus.fe_halt) bus.fe_rd_data <= rom(bus.fe_rd_addr);
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  localparam logic ExpMis = 1'b1;
`else
  localparam logic ExpMis = 1'b0;
`endif

  typedef struct {
    logic        halt;
    logic        br_en;
    logic [31:0] br_target;
    logic        rdy;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic        exp_rd_en;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic add(input logic h, input logic b, input logic [31:0] t, input logic r,
                     input logic ev, input logic [31:0] epc, input logic [31:0] ein,
                     input logic erd, input logic [31:0] ea);
    vec_t v;
    v.halt = h; v.br_en = b; v.br_target = t; v.rdy = r;
    v.exp_valid = ev; v.exp_pc = epc; v.exp_instr = ein;
    v.exp_rd_en = erd; v.exp_addr = ea;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic h, input logic b, input logic [31:0] t, input logic r);
    halt = h; bus.br_en = b; bus.br_target = t; bus.i_ready = r;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    @(negedge clk);
    chk({tag, " o_valid"}, 32'(bus.o_valid), 32'd0);
    chk({tag, " o_pc"}, bus.o_pc, 32'h0);
    chk({tag, " o_instr"}, bus.o_instr, 32'h0);
    chk({tag, " o_misalign"}, 32'(bus.o_misalign), 32'd0);
    chk({tag, " fe_rd_en"}, 32'(bus.fe_rd_en), 32'd0);
    chk({tag, " fe_halt"}, 32'(bus.fe_halt), 32'd1);
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc, input logic [31:0] ins);
    @(negedge clk);
    chk({tag, " o_valid"}, 32'(bus.o_valid), 32'd1);
    chk({tag, " o_pc"}, bus.o_pc, pc);
    chk({tag, " o_instr"}, bus.o_instr, ins);
  endtask

  initial begin
    reset = 1'b1;
    bus.fe_rd_data = '0;
    drive(1'b0, 1'b0, 32'h0, 1'b1);

    // Cycle-by-cycle script; row index == cycle number after reset release.
    add(0, 0, 32'h00, 1, 0, 32'h00, 32'h000, 1, 32'h00);  // 0
    add(0, 0, 32'h00, 1, 0, 32'h00, 32'h000, 1, 32'h04);  // 1
    add(0, 0, 32'h00, 1, 1, 32'h00, 32'h011, 1, 32'h08);  // 2
    add(0, 0, 32'h00, 0, 1, 32'h04, 32'h022, 0, 32'h00);  // 3  stall, queue fills
    add(0, 0, 32'h00, 0, 1, 32'h04, 32'h022, 0, 32'h00);  // 4
    add(0, 0, 32'h00, 0, 1, 32'h04, 32'h022, 0, 32'h00);  // 5
    add(0, 0, 32'h00, 0, 1, 32'h04, 32'h022, 0, 32'h00);  // 6
    add(0, 0, 32'h00, 0, 1, 32'h04, 32'h022, 0, 32'h00);  // 7
    add(0, 0, 32'h00, 1, 1, 32'h04, 32'h022, 1, 32'h0C);  // 8  release
    add(0, 0, 32'h00, 1, 1, 32'h08, 32'h033, 1, 32'h10);  // 9
    add(0, 1, 32'h40, 0, 1, 32'h0C, 32'h044, 0, 32'h00);  // 10 redirect, word in flight
    add(0, 0, 32'h00, 1, 0, 32'h00, 32'h000, 1, 32'h40);  // 11
    add(0, 0, 32'h00, 1, 0, 32'h00, 32'h000, 1, 32'h44);  // 12
    add(0, 0, 32'h00, 1, 1, 32'h40, 32'h121, 1, 32'h48);  // 13
    add(1, 0, 32'h00, 1, 1, 32'h44, 32'h132, 0, 32'h00);  // 14 halt x3
    add(1, 0, 32'h00, 1, 1, 32'h44, 32'h132, 0, 32'h00);  // 15
    add(1, 0, 32'h00, 1, 1, 32'h44, 32'h132, 0, 32'h00);  // 16
    add(0, 0, 32'h00, 1, 1, 32'h44, 32'h132, 1, 32'h4C);  // 17
    add(0, 0, 32'h00, 1, 1, 32'h48, 32'h143, 1, 32'h50);  // 18
    add(1, 1, 32'h80, 1, 1, 32'h4C, 32'h154, 0, 32'h00);  // 19 halt + redirect
    add(0, 0, 32'h00, 1, 0, 32'h00, 32'h000, 1, 32'h80);  // 20
    add(0, 0, 32'h00, 1, 0, 32'h00, 32'h000, 1, 32'h84);  // 21
    add(0, 0, 32'h00, 1, 1, 32'h80, 32'h231, 1, 32'h88);  // 22

    next_cycle();
    next_cycle();
    check_reset_state("reset");
    next_cycle();
    reset = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].halt, vecs[i].br_en, vecs[i].br_target, vecs[i].rdy);
      @(negedge clk);
      chk($sformatf("c%0d o_valid", i), 32'(bus.o_valid), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) begin
        chk($sformatf("c%0d o_pc", i), bus.o_pc, vecs[i].exp_pc);
        chk($sformatf("c%0d o_instr", i), bus.o_instr, vecs[i].exp_instr);
      end
      chk($sformatf("c%0d fe_rd_en", i), 32'(bus.fe_rd_en), 32'(vecs[i].exp_rd_en));
      chk($sformatf("c%0d fe_halt", i), 32'(bus.fe_halt), 32'(!vecs[i].exp_rd_en));
      if (vecs[i].exp_rd_en) begin
        chk($sformatf("c%0d fe_rd_addr", i), bus.fe_rd_addr, vecs[i].exp_addr);
      end
      chk($sformatf("c%0d o_misalign", i), 32'(bus.o_misalign), 32'd0);
      next_cycle();
    end

    // Reset in the middle of a running stream.
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    reset = 1'b1;
    next_cycle();
    check_reset_state("midreset");
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    chk("rst c0 o_valid", 32'(bus.o_valid), 32'd0);
    chk("rst c0 fe_rd_addr", bus.fe_rd_addr, 32'h0);
    next_cycle();
    @(negedge clk);
    chk("rst c1 o_valid", 32'(bus.o_valid), 32'd0);
    next_cycle();
    check_head("rst c2", 32'h0, 32'h11);
    next_cycle();
    check_head("rst c3", 32'h4, 32'h22);
    next_cycle();

    // Misaligned redirect lands on the aligned address.
    drive(1'b0, 1'b1, 32'h42, 1'b1);
    @(negedge clk);
    chk("mis br fe_rd_en", 32'(bus.fe_rd_en), 32'd0);
    next_cycle();
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    chk("mis fe_rd_addr", bus.fe_rd_addr, 32'h40);
    chk("mis fe_rd_en", 32'(bus.fe_rd_en), 32'd1);
    chk("mis o_misalign set", 32'(bus.o_misalign), 32'(ExpMis));
    next_cycle();
    @(negedge clk);
    chk("mis +2 o_valid", 32'(bus.o_valid), 32'd0);
    next_cycle();
    check_head("mis +3", 32'h40, 32'h121);
    next_cycle();
    check_head("mis +4", 32'h44, 32'h132);
    chk("mis sticky", 32'(bus.o_misalign), 32'(ExpMis));
    next_cycle();
    reset = 1'b1;
    next_cycle();
    check_reset_state("mis reset");
    next_cycle();
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
